ring_phase_monitor: RTL and testbench

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_phase_monitor_if.sv | 16 +
 rtl/ring_phase_monitor.sv | 109 ++++++++++
 tb/tb_ring_phase_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if: control and status bundle between a ring-phase source and its monitor
interface ring_phase_monitor_if #(parameter int REV_W = 8);
    logic             en;
    logic [3:0]       phase_in;
    logic             clr_err;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_code;
    logic [1:0]       phase_idx;
    logic             rev_tick;
    logic [REV_W-1:0] rev_count;
    modport master(output en, phase_in, clr_err,
                   input locked, fault, fault_code, phase_idx, rev_tick, rev_count);
    modport slave(input en, phase_in, clr_err,
                  output locked, fault, fault_code, phase_idx, rev_tick, rev_count);
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot 4-phase ring for legality and order, locks and counts revolutions
// Define RING_STALL_EN to accept a repeated phase as a stall instead of an out-of-sequence error.
module ring_phase_monitor #(
    parameter int REV_W = 8,
    parameter int SYNC_REVS = 2
) (
    input logic clk,
    input logic rst,
    ring_phase_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;
    state_t           st;
    logic [3:0]       prev;
    logic             prev_v;
    logic [3:0]       good;
    logic             locked_q, fault_q, tick_q;
    logic [1:0]       code_q, idx_q;
    logic [REV_W-1:0] cnt_q;
    logic [3:0]       succ;
    logic             illegal, stall, oos, rev;
    logic [1:0]       pidx;
    always_comb begin
        succ    = {prev[0], prev[3:1]};
        illegal = !$onehot(bus.phase_in);
`ifdef RING_STALL_EN
        stall   = prev_v && bus.phase_in == prev;
`else
        stall   = 1'b0;
`endif
        oos     = prev_v && !stall && bus.phase_in != succ;
        rev     = prev_v && prev == 4'b0010 && bus.phase_in == 4'b0001;
        pidx    = {bus.phase_in[3] | bus.phase_in[2], bus.phase_in[3] | bus.phase_in[1]};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            st       <= IDLE;
            prev     <= 4'b0000;
            prev_v   <= 1'b0;
            good     <= 4'd0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
            idx_q    <= 2'b00;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            tick_q <= 1'b0;
            case (st)
                IDLE: begin
                    prev_v <= 1'b0;
                    good   <= 4'd0;
                    if (bus.en) st <= SYNC;
                end
                SYNC, LOCKED: begin
                    if (!bus.en) begin
                        st       <= IDLE;
                        prev_v   <= 1'b0;
                        locked_q <= 1'b0;
                        idx_q    <= 2'b00;
                    end else if (illegal || (oos && st == LOCKED)) begin
                        st       <= FAULT;
                        fault_q  <= 1'b1;
                        locked_q <= 1'b0;
                        idx_q    <= 2'b00;
                        code_q   <= illegal ? 2'b01 : 2'b10;
                    end else if (oos) begin
                        good <= 4'd0;
                        prev <= bus.phase_in;
                    end else begin
                        prev   <= bus.phase_in;
                        prev_v <= 1'b1;
                        if (st == LOCKED) begin
                            idx_q <= pidx;
                            if (rev) begin
                                tick_q <= 1'b1;
                                cnt_q  <= cnt_q + 1'b1;
                            end
                        end else if (rev) begin
                            if (good == 4'(SYNC_REVS - 1)) begin
                                st       <= LOCKED;
                                locked_q <= 1'b1;
                                cnt_q    <= '0;
                                idx_q    <= pidx;
                                good     <= 4'd0;
                            end else begin
                                good <= good + 1'b1;
                            end
                        end
                    end
                end
                FAULT: begin
                    if (bus.clr_err) begin
                        st      <= bus.en ? SYNC : IDLE;
                        fault_q <= 1'b0;
                        code_q  <= 2'b00;
                        prev_v  <= 1'b0;
                        good    <= 4'd0;
                    end
                end
            endcase
        end
    end
    assign bus.locked     = locked_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.phase_idx  = idx_q;
    assign bus.rev_tick   = tick_q;
    assign bus.rev_count  = cnt_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed vectors against hand-computed expectations, REV_W=2, SYNC_REVS=2
module tb_ring_phase_monitor;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    ring_phase_monitor_if #(.REV_W(2)) bus();
    ring_phase_monitor #(.REV_W(2), .SYNC_REVS(2)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic [3:0] ph);
        bus.phase_in = ph;
        @(posedge clk);
        #1;
    endtask
    task automatic rev();
        step(4'b1000);
        step(4'b0100);
        step(4'b0010);
        step(4'b0001);
    endtask
    task automatic relock();
        step(4'b0001);
        rev();
        rev();
    endtask
    initial begin
        rst = 1'b0;
        bus.en = 1'b0;
        bus.clr_err = 1'b0;
        bus.phase_in = 4'b0000;
        step(4'b0001);
        chk("rst_locked", bus.locked, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_code", bus.fault_code, 0);
        chk("rst_idx", bus.phase_idx, 0);
        chk("rst_tick", bus.rev_tick, 0);
        chk("rst_cnt", bus.rev_count, 0);
        rst = 1'b1;
        bus.en = 1'b1;
        step(4'b0001);
        step(4'b0001);
        rev();
        step(4'b1000);
        step(4'b0100);
        step(4'b0010);
        chk("pre_lock", bus.locked, 0);
        step(4'b0001);
        chk("lock", bus.locked, 1);
        chk("lock_cnt", bus.rev_count, 0);
        chk("lock_tick", bus.rev_tick, 0);
        for (int r = 1; r <= 3; r++) begin
            step(4'b1000);
            chk("tick_low", bus.rev_tick, 0);
            chk("idx3", bus.phase_idx, 3);
            step(4'b0100);
            step(4'b0010);
            chk("idx1", bus.phase_idx, 1);
            step(4'b0001);
            chk("tick_rev", bus.rev_tick, 1);
            chk("cnt_rev", bus.rev_count, r);
        end
        rev();
        chk("wrap_cnt", bus.rev_count, 0);
        chk("wrap_tick", bus.rev_tick, 1);
        rev();
        chk("cnt_one", bus.rev_count, 1);
        step(4'b0110);
        chk("ill_fault", bus.fault, 1);
        chk("ill_code", bus.fault_code, 2'b01);
        chk("ill_locked", bus.locked, 0);
        chk("ill_idx", bus.phase_idx, 0);
        bus.en = 1'b0;
        repeat (5) step(4'b0110);
        chk("hold_fault", bus.fault, 1);
        chk("hold_code", bus.fault_code, 2'b01);
        chk("hold_cnt", bus.rev_count, 1);
        bus.en = 1'b1;
        bus.clr_err = 1'b1;
        step(4'b0001);
        bus.clr_err = 1'b0;
        chk("clr_fault", bus.fault, 0);
        chk("clr_code", bus.fault_code, 0);
        chk("clr_cnt", bus.rev_count, 1);
        step(4'b0001);
        rev();
        step(4'b1000);
        step(4'b0010);
        chk("sync_jump_nofault", bus.fault, 0);
        step(4'b0001);
        chk("sync_restart", bus.locked, 0);
        rev();
        chk("relock", bus.locked, 1);
        chk("relock_cnt", bus.rev_count, 0);
        step(4'b1000);
        step(4'b0010);
        chk("jump_fault", bus.fault, 1);
        chk("jump_code", bus.fault_code, 2'b10);
        chk("jump_locked", bus.locked, 0);
        bus.clr_err = 1'b1;
        step(4'b0001);
        bus.clr_err = 1'b0;
        relock();
        chk("relock2", bus.locked, 1);
        rev();
        bus.en = 1'b0;
        step(4'b1000);
        chk("en_off_locked", bus.locked, 0);
        chk("en_off_cnt", bus.rev_count, 1);
        chk("en_off_idx", bus.phase_idx, 0);
        bus.en = 1'b1;
        step(4'b0001);
        relock();
        chk("relock3", bus.locked, 1);
        step(4'b1000);
        step(4'b0100);
        step(4'b0100);
        step(4'b0100);
`ifdef RING_STALL_EN
        chk("stall_fault", bus.fault, 0);
        chk("stall_locked", bus.locked, 1);
        chk("stall_idx", bus.phase_idx, 2);
`else
        chk("stall_fault", bus.fault, 1);
        chk("stall_code", bus.fault_code, 2'b10);
        chk("stall_locked", bus.locked, 0);
`endif
        step(4'b0000);
        chk("zero_fault", bus.fault, 1);
`ifdef RING_STALL_EN
        chk("zero_code", bus.fault_code, 2'b01);
`else
        chk("zero_code", bus.fault_code, 2'b10);
`endif
        rst = 1'b0;
        bus.clr_err = 1'b1;
        step(4'b0001);
        chk("mid_rst_fault", bus.fault, 0);
        chk("mid_rst_code", bus.fault_code, 0);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_cnt", bus.rev_count, 0);
        chk("mid_rst_idx", bus.phase_idx, 0);
        rst = 1'b1;
        bus.clr_err = 1'b0;
        bus.en = 1'b0;
        step(4'b0001);
        step(4'b0001);
        chk("idle_locked", bus.locked, 0);
        chk("idle_fault", bus.fault, 0);
        bus.en = 1'b1;
        step(4'b0001);
        relock();
        chk("final_lock", bus.locked, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
